mult_share_arbiter: RTL and testbench
=====================================

// Module: mult_share_arbiter
// PURPOSE
//  Shares one sequential_multiplier (start/done handshake, signed, low-WIDTH product) between NUM_REQ requesters.
//  - Round-robin arbitration; one operation in flight at a time.
//  - Latches the winner's operands, drives the multiplier start pulse and waits for done.
//  - Routes the product back to the winning requester with a one-cycle valid pulse.
// PARAMETERS
//  NUM_REQ        4   number of requesters (2..8)
//  WIDTH          32  operand/product width; matches the multiplier
//  TIMEOUT_CYCLES 64  watchdog limit in WAIT; used only when MUL_ARB_TIMEOUT_EN is defined
// PORTS
//  clk         in   1               single clock, rising edge
//  rst         in   1               asynchronous, active-low reset (0 = reset)
//  req_valid   in   NUM_REQ         per-requester request; held until its req_ready
//  req_a       in   NUM_REQ*WIDTH   packed multiplicands; slice i = [i*WIDTH +: WIDTH], signed
//  req_b       in   NUM_REQ*WIDTH   packed multipliers, same packing
//  req_ready   out  NUM_REQ         one-hot, 1-cycle acceptance pulse
//  resp_valid  out  NUM_REQ         one-hot, 1-cycle result pulse to the owning requester
//  resp_data   out  WIDTH           product; valid only while any resp_valid is high
//  resp_err    out  1               watchdog error flag, qualified by resp_valid; tied 0 without macro
//  busy        out  1               high in every state except IDLE
//  mul_start   out  1               start pulse to the multiplier
//  mul_a/mul_b out  WIDTH           operands to the multiplier; stable from ISSUE through WAIT
//  mul_product in   WIDTH           multiplier product
//  mul_done    in   1               multiplier done; only the rising edge is used
// BEHAVIOUR
//  Reset values: all outputs 0; FSM in IDLE; rr_ptr 0; done_q 0; owner 0.
//  States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  - IDLE: if req_valid != 0, grant the first set bit scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//    - Same cycle: req_ready[g] = 1 (combinational from registered state and inputs).
//    - On the clock edge: latch a/b[g] into mul_a/mul_b, set owner = g, rr_ptr = (g+1) mod NUM_REQ.
//    - If req_valid == 0, stay in IDLE.
//  - ISSUE: mul_start = 1 for exactly one cycle -> WAIT.
//  - WAIT: done_q is mul_done registered every cycle.
//    - mul_done & ~done_q (rising edge): capture mul_product into resp_data -> RESP.
//    - A done level left high from a prior op does not complete the op.
//  - RESP: resp_valid[owner] = 1 for one cycle; resp_data held -> IDLE.
//    - A new grant is possible on the next cycle.
//  - Latency: grant at cycle T, mul_start at T+1, done edge at cycle D, resp_valid at D+1.
//    Minimum turnaround between grants is 4 cycles plus the multiplier time.
//  - Arithmetic: no width change. resp_data = low WIDTH bits of the signed product as delivered;
//    overflow wraps silently.
//  - Requests are sampled only in IDLE. req_valid deasserted before grant = request withdrawn, no side effect.
//  - A requester that re-asserts during ISSUE/WAIT/RESP competes at the next IDLE under the updated rr_ptr.
//  - mul_done edges seen in IDLE/ISSUE/RESP are ignored.
//  - Reset asserted in any state: immediate return to IDLE, outputs cleared, in-flight result discarded,
//    no resp_valid issued.
// CONFIGURATION
//  MUL_ARB_TIMEOUT_EN defined:
//  - A counter clears on entry to WAIT and increments each WAIT cycle.
//  - Reaching TIMEOUT_CYCLES with no done edge -> RESP with resp_err = 1 and resp_data = 0.
//  - A done edge in the same cycle as the limit takes priority: normal result, resp_err = 0.
//  - The multiplier is not reset by this block.
//  MUL_ARB_TIMEOUT_EN undefined: no counter; WAIT waits indefinitely; resp_err is constant 0.
// TESTING
//  1. req_valid = 0001, a0 = 5, b0 = -3 -> req_ready = 0001 for 1 cycle, mul_start 1 cycle later,
//     resp_valid = 0001, resp_data = -15, resp_err = 0.
//  2. Same cycle: req0 = (4,7), req2 = (-6,-4) -> req0 served first (28); req2 is then granted
//     at the next IDLE (24); outputs return to the correct one-hot bits.
//  3. All four requesting continuously with a_i = i+1, b_i = 10 -> grant order 0,1,2,3,0,1;
//     results 10,20,30,40,10,20.
//  4. req1 = (-2147483647, 2) -> resp_data = 32'h0000_0002 (wrapped low bits);
//     req3 = (123, 0) -> 0; req0 = (456, 1) -> 456.
//  5. Reset pulled low during WAIT, before done -> all outputs 0 asynchronously, no resp_valid;
//     after release, req = (1000, 2000) -> 2000000 and rr_ptr restarts at 0.
//  6. With MUL_ARB_TIMEOUT_EN: mul_done held 0 -> resp_valid with resp_err = 1 and resp_data = 0
//     exactly 64 WAIT cycles after entry.
//     Without the macro, the same stimulus leaves busy = 1 with no resp_valid for 200 cycles.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Shares one start/done sequential multiplier between NUM_REQ requesters. A round-robin
//   grant latches the winner's operands, pulses mul_start, waits for the rising edge of
//   mul_done, then returns the product to the owner with a one-cycle resp_valid pulse.
//   Only one operation is in flight at a time.
//
// Ports
//   clk, rst              clock (rising edge); asynchronous active-low reset
//   req_valid/req_a/req_b per-requester request and packed signed operands (slice i*WIDTH)
//   req_ready             one-hot, combinational acceptance pulse in IDLE
//   resp_valid/resp_data  one-hot result pulse and product
//   resp_err              watchdog error, qualified by resp_valid (0 without the watchdog)
//   busy                  high in every state except IDLE
//   mul_start/mul_a/mul_b multiplier start pulse and operands
//   mul_product/mul_done  multiplier result and done
//
// Build option
//   MUL_ARB_TIMEOUT_EN    enables the WAIT watchdog (TIMEOUT_CYCLES)
`timescale 1ns / 1ps
module mult_share_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         resp_valid,
  output logic [WIDTH-1:0]           resp_data,
  output logic                       resp_err,
  output logic                       busy,
  output logic                       mul_start,
  output logic [WIDTH-1:0]           mul_a,
  output logic [WIDTH-1:0]           mul_b,
  input  logic [WIDTH-1:0]           mul_product,
  input  logic                       mul_done
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state_q;
  logic [IdxW-1:0] rr_ptr_q;
  logic [IdxW-1:0] owner_q;
  logic            done_q;

  logic            grant_vld;
  logic [IdxW-1:0] grant_idx;
  logic [IdxW-1:0] scan_idx;

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] wd_cnt_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign resp_err       = 1'b0;
`endif

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = IdxW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_vld && req_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // Gated by rst so every output reads 0 while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst && (state_q == StIdle) && grant_vld) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      done_q     <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_start  <= 1'b0;
      resp_valid <= '0;
      resp_data  <= '0;
      busy       <= 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
      resp_err   <= 1'b0;
      wd_cnt_q   <= '0;
`endif
    end else begin
      done_q     <= mul_done;
      mul_start  <= 1'b0;
      resp_valid <= '0;
      unique case (state_q)
        StIdle: begin
          if (grant_vld) begin
            mul_a     <= req_a[32'(grant_idx)*WIDTH +: WIDTH];
            mul_b     <= req_b[32'(grant_idx)*WIDTH +: WIDTH];
            owner_q   <= grant_idx;
            rr_ptr_q  <= (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
            mul_start <= 1'b1;
            busy      <= 1'b1;
            state_q   <= StIssue;
          end
        end
        StIssue: begin
`ifdef MUL_ARB_TIMEOUT_EN
          wd_cnt_q <= '0;
`endif
          state_q <= StWait;
        end
        StWait: begin
          // Edge, not level: a done still high from the previous op must not complete this one.
          if (mul_done && !done_q) begin
            resp_data           <= mul_product;
            resp_valid[owner_q] <= 1'b1;
`ifdef MUL_ARB_TIMEOUT_EN
            resp_err            <= 1'b0;
`endif
            state_q             <= StResp;
          end
`ifdef MUL_ARB_TIMEOUT_EN
          else if (wd_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            resp_data           <= '0;
            resp_err            <= 1'b1;
            resp_valid[owner_q] <= 1'b1;
            state_q             <= StResp;
          end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
          end
`endif
        end
        StResp: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
`timescale 1ns / 1ps
module tb_mult_share_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready, resp_valid;
  logic [W-1:0]   resp_data, mul_a, mul_b, mul_product;
  logic           resp_err, busy, mul_start, mul_done;

  mult_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .busy(busy), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_product(mul_product), .mul_done(mul_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Requester side: what each requester currently asks for.
  logic [N-1:0] want  = '0;
  logic [N-1:0] rearm = '0;
  logic [W-1:0] want_a[N];
  logic [W-1:0] want_b[N];

  // Reference model of the arbiter (transaction level).
  int       rr = 0, owner = 0, start_cyc = -1, resp_cyc = -1;
  bit       inflight = 0, exp_err = 0;
  logic [W-1:0] exp_a, exp_b, exp_data;

  // Multiplier model.
  bit       hang = 0, stale_hi = 0, pulse_on = 0;
  int       stale_until = 0, done_cyc = 0, done_len = 0, force_lat = 0;
  logic [W-1:0] mprod;

  int           grant_log[$];
  int           owner_log[$];
  logic [W-1:0] data_log[$];
  bit           err_log[$];

  function automatic int pick(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [W-1:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'h0;
      3:       return 32'(int'($urandom_range(0, 40)) - 20);
      default: return $urandom;
    endcase
  endfunction

  task automatic clear_logs();
    grant_log.delete(); owner_log.delete(); data_log.delete(); err_log.delete();
  endtask

  // One clock cycle: drive inputs at the falling edge, settle, compare, advance the model.
  task automatic step();
    logic [N-1:0] exp_ready, exp_rv;
    int g, lat;
    bit in_pulse;
    @(negedge clk);
    cyc++;
    req_valid = want;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = want_a[i];
      req_b[i*W +: W] = want_b[i];
    end
    in_pulse    = pulse_on && (cyc >= done_cyc) && (cyc < done_cyc + done_len);
    mul_done    = stale_hi || (cyc < stale_until) || in_pulse;
    mul_product = in_pulse ? mprod : $urandom;
    #1;
    exp_ready = '0;
    g = -1;
    if (!inflight && want != '0) begin
      g = pick(rr, want);
      exp_ready[g] = 1'b1;
    end
    exp_rv = '0;
    if (cyc == resp_cyc) exp_rv[owner] = 1'b1;
    check("req_ready", req_ready, exp_ready);
    check("busy", busy, inflight);
    check("mul_start", mul_start, cyc == start_cyc);
    check("resp_valid", resp_valid, exp_rv);
    if (cyc == resp_cyc) begin
      check("resp_data", resp_data, exp_data);
      check("resp_err", resp_err, exp_err);
      owner_log.push_back(owner);
      data_log.push_back(resp_data);
      err_log.push_back(resp_err);
      inflight = 0;
    end
    if (cyc == start_cyc) begin
      check("mul_a", mul_a, exp_a);
      check("mul_b", mul_b, exp_b);
      if (hang) begin
        pulse_on = 0;
`ifdef MUL_ARB_TIMEOUT_EN
        resp_cyc = cyc + 1 + TO;
        exp_data = '0;
        exp_err  = 1;
`endif
      end else begin
        lat = (force_lat > 0) ? force_lat : $urandom_range(1, 5);
        if (stale_hi) begin
          stale_until = cyc + 2;
          stale_hi    = 0;
          lat += 2;
        end
        done_cyc = cyc + lat;
        done_len = $urandom_range(1, 3);
        pulse_on = 1;
        mprod    = smul(mul_a, mul_b);
        resp_cyc = done_cyc + 1;
      end
    end
    if (g >= 0) begin
      owner     = g;
      exp_a     = want_a[g];
      exp_b     = want_b[g];
      exp_data  = smul(want_a[g], want_b[g]);
      exp_err   = 0;
      rr        = (g + 1) % N;
      inflight  = 1;
      start_cyc = cyc + 1;
      resp_cyc  = -1;
      grant_log.push_back(g);
      if (!rearm[g]) want[g] = 1'b0;
    end
  endtask

  task automatic run_until_quiet(input int max_cyc);
    int n = 0;
    while ((inflight || want != '0) && n < max_cyc) begin
      step();
      n++;
    end
    check("quiet_within_budget", inflight || (want != '0), 0);
  endtask

  // Reset asserted between clock edges; outputs must clear without waiting for a clock.
  task automatic apply_reset();
    #2;
    rst       = 1'b0;
    req_valid = '1;
    mul_done  = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_busy", busy, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    inflight = 0; rr = 0; start_cyc = -1; resp_cyc = -1;
    pulse_on = 0; stale_hi = 0; stale_until = 0; hang = 0; force_lat = 0;
    want = '0; rearm = '0;
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    for (int i = 0; i < N; i++) begin
      want_a[i] = '0;
      want_b[i] = '0;
    end
    req_valid = '0; req_a = '0; req_b = '0; mul_done = 1'b0; mul_product = '0;
    apply_reset();

    // Single request, negative product.
    clear_logs();
    want_a[0] = 32'd5; want_b[0] = 32'hFFFF_FFFD; want[0] = 1'b1;
    run_until_quiet(50);
    check("t1_count", data_log.size(), 1);
    check("t1_data", data_log[0], 32'hFFFF_FFF1);
    check("t1_err", err_log[0], 0);

    // Done left high from before must not complete the next op.
    clear_logs();
    stale_hi = 1;
    want_a[1] = 32'd7; want_b[1] = 32'd6; want[1] = 1'b1;
    run_until_quiet(50);
    check("stale_data", data_log[0], 32'd42);

    // Two simultaneous requests.
    apply_reset();
    clear_logs();
    want_a[0] = 32'd4; want_b[0] = 32'd7;
    want_a[2] = 32'hFFFF_FFFA; want_b[2] = 32'hFFFF_FFFC;
    want = 4'b0101;
    run_until_quiet(80);
    check("t2_count", data_log.size(), 2);
    check("t2_owner0", owner_log[0], 0);
    check("t2_data0", data_log[0], 32'd28);
    check("t2_owner1", owner_log[1], 2);
    check("t2_data1", data_log[1], 32'd24);

    // All four requesting continuously.
    apply_reset();
    clear_logs();
    for (int i = 0; i < N; i++) begin
      want_a[i] = 32'(i + 1);
      want_b[i] = 32'd10;
    end
    want = '1; rearm = '1;
    n = 0;
    while (grant_log.size() < 6 && n < 200) begin
      step();
      n++;
    end
    want = '0; rearm = '0;
    run_until_quiet(50);
    check("t3_count", data_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check("t3_grant", grant_log[i], i % 4);
      check("t3_data", data_log[i], 32'(10 * ((i % 4) + 1)));
    end

    // Wrap-around and zero/identity products.
    clear_logs();
    want_a[1] = 32'h8000_0001; want_b[1] = 32'd2; want[1] = 1'b1;
    run_until_quiet(50);
    want_a[3] = 32'd123; want_b[3] = 32'd0; want[3] = 1'b1;
    run_until_quiet(50);
    want_a[0] = 32'd456; want_b[0] = 32'd1; want[0] = 1'b1;
    run_until_quiet(50);
    check("t4_count", data_log.size(), 3);
    check("t4_wrap", data_log[0], 32'h0000_0002);
    check("t4_zero", data_log[1], 32'd0);
    check("t4_ident", data_log[2], 32'd456);

    // Reset during WAIT discards the op; round robin restarts at 0.
    apply_reset();
    clear_logs();
    force_lat = 30;
    want_a[2] = 32'd11; want_b[2] = 32'd13; want[2] = 1'b1;
    n = 0;
    while (!(start_cyc > 0 && cyc >= start_cyc + 3) && n < 60) begin
      step();
      n++;
    end
    check("t5_in_wait", busy, 1);
    apply_reset();
    check("t5_no_resp", data_log.size(), 0);
    clear_logs();
    want_a[0] = 32'd1000; want_b[0] = 32'd2000;
    want_a[3] = 32'd5;    want_b[3] = 32'd5;
    want = 4'b1001;
    run_until_quiet(80);
    check("t5_first_grant", grant_log[0], 0);
    check("t5_data", data_log[0], 32'd2_000_000);

    // Multiplier that never answers.
    apply_reset();
    clear_logs();
    hang = 1;
    want_a[0] = 32'd3; want_b[0] = 32'd3; want[0] = 1'b1;
`ifdef MUL_ARB_TIMEOUT_EN
    run_until_quiet(200);
    check("t6_count", data_log.size(), 1);
    check("t6_err", err_log[0], 1);
    check("t6_data", data_log[0], 0);
`else
    for (int i = 0; i < 200; i++) step();
    check("t6_no_resp", data_log.size(), 0);
    check("t6_busy", busy, 1);
`endif
    apply_reset();

    // Randomized traffic with withdrawals.
    clear_logs();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!want[i] && $urandom_range(0, 3) == 0) begin
          want[i]   = 1'b1;
          want_a[i] = rand_op();
          want_b[i] = rand_op();
        end else if (want[i] && $urandom_range(0, 49) == 0) begin
          want[i] = 1'b0;
        end
      end
      step();
    end
    run_until_quiet(200);
    check("rand_some_traffic", data_log.size() > 50, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
